gfx_cmd_writer: RTL and testbench

- Producer side of the `operation`/`data` write port that the pixel compute block consumes.
- Takes high-level commands from the CPU-side logic over a valid/ready handshake: a single write to any target, or a rectangular tile fill of the board.
- Turns each command into a timed sequence of `operation`/`data` words.
- The sequence respects the consumer's one-cycle registered write-enable. No stray or lost writes occur.

---
 rtl/gfx_cmd_writer_pkg.sv | 57 +++++
 rtl/gfx_cmd_writer_if.sv | 40 ++++
 rtl/gfx_cmd_writer_rect_walker.sv | 99 +++++++++
 rtl/gfx_cmd_writer.sv | 137 +++++++++++++
 tb/tb_gfx_cmd_writer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gfx_cmd_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gfx_pkg
// Description : Shared constants, state encoding and helper functions for
//               the graphics command writer.
// Revision    : 1.0 - initial release
// ============================================================================
package gfx_pkg;

    // Write targets carried in operation[17:16]
    localparam logic [1:0] TGT_NONE    = 2'b00;
    localparam logic [1:0] TGT_BOARD   = 2'b01;
    localparam logic [1:0] TGT_SPRITES = 2'b10;
    localparam logic [1:0] TGT_COLORS  = 2'b11;

    // Board geometry
    localparam int BOARD_COLS = 80;
    localparam int BOARD_ROWS = 34;

    // Operation word layout
    localparam int OP_ADDR_LSB = 0;
    localparam int OP_ADDR_W   = 16;
    localparam int OP_TGT_LSB  = 16;
    localparam int OP_TGT_W    = 2;

    // Writer state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_PRIME = 3'd1;
    localparam state_t c_ST_WRITE = 3'd2;
    localparam state_t c_ST_TAIL  = 3'd3;
    localparam state_t c_ST_DONE  = 3'd4;

    // Pack target and address into an operation word; bits [31:18] stay zero.
    function automatic logic [31:0] make_op(input logic [1:0] tgt, input logic [15:0] addr);
        logic [31:0] v;
        v = '0;
        v[OP_TGT_LSB +: OP_TGT_W]   = tgt;
        v[OP_ADDR_LSB +: OP_ADDR_W] = addr;
        return v;
    endfunction

    // y * cols as a sum of shifted copies of y; with a constant cols this
    // reduces to a couple of adders (80 = 64 + 16).
    function automatic logic [15:0] mul_cols(input logic [5:0] y, input int cols);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (cols[i]) begin
                acc = acc + (16'(y) << i);
            end
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gfx_cmd_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : gfx_cmd_writer_if
// Description : Command handshake from the CPU side plus the operation/data
//               write port towards the pixel compute block.
// Revision    : 1.0 - initial release
// ============================================================================
interface gfx_cmd_writer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_fill;
    logic [1:0]  cmd_target;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [6:0]  rect_x;
    logic [5:0]  rect_y;
    logic [6:0]  rect_w;
    logic [5:0]  rect_h;
    logic [31:0] operation;
    logic [31:0] data;
    logic        busy;
    logic        done;

    // Command issuer
    modport master (
        output cmd_valid, cmd_fill, cmd_target, cmd_addr, cmd_data,
               rect_x, rect_y, rect_w, rect_h,
        input  cmd_ready, operation, data, busy, done
    );

    // Command writer
    modport slave (
        input  cmd_valid, cmd_fill, cmd_target, cmd_addr, cmd_data,
               rect_x, rect_y, rect_w, rect_h,
        output cmd_ready, operation, data, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/gfx_cmd_writer_rect_walker.sv
`default_nettype none
// ============================================================================
// Module      : rect_walker
// Description : Holds a clipped fill rectangle and walks it row-major,
//               producing the board address of the current tile and a flag
//               marking the final tile. Row base is kept incrementally.
// Revision    : 1.0 - initial release
// ============================================================================
module rect_walker #(
    parameter int BOARD_COLS = 80,
    parameter int BOARD_ROWS = 34
) (
    input  wire logic        clock,
    input  wire logic        reset,
    input  wire logic        load,
    input  wire logic        prime,
    input  wire logic        step,
    input  wire logic [6:0]  rect_x,
    input  wire logic [5:0]  rect_y,
    input  wire logic [6:0]  rect_w,
    input  wire logic [5:0]  rect_h,
    output logic             empty,
    output logic [15:0]      addr,
    output logic             last
);
    import gfx_pkg::mul_cols;

    localparam logic [7:0]  c_COLS8  = 8'(BOARD_COLS);
    localparam logic [6:0]  c_ROWS7  = 7'(BOARD_ROWS);
    localparam logic [15:0] c_COLS16 = 16'(BOARD_COLS);

    logic [6:0]  r_x0;
    logic [6:0]  r_x;
    logic [5:0]  r_y;
    logic [7:0]  r_x_end;
    logic [6:0]  r_y_end;
    logic [15:0] r_row_base;

    logic [7:0]  w_x_sum;
    logic [7:0]  w_x_end;
    logic [6:0]  w_y_sum;
    logic [6:0]  w_y_end;
    logic [7:0]  w_x_next;
    logic [6:0]  w_y_next;
    logic        w_row_wrap;
    logic [15:0] w_prime_base;
    logic [15:0] w_base;

    // Clip limits are computed one bit wider than the fields so the
    // comparison sees the true sum.
    assign w_x_sum = {1'b0, rect_x} + {1'b0, rect_w};
    assign w_y_sum = {1'b0, rect_y} + {1'b0, rect_h};
    assign w_x_end = (w_x_sum > c_COLS8) ? c_COLS8 : w_x_sum;
    assign w_y_end = (w_y_sum > c_ROWS7) ? c_ROWS7 : w_y_sum;

    assign empty = (rect_w == '0) || (rect_h == '0) ||
                   ({1'b0, rect_x} >= c_COLS8) || ({1'b0, rect_y} >= c_ROWS7);

    // During the first word the row base is not registered yet, so the
    // shift-add product is used directly and captured at the same time.
    assign w_prime_base = mul_cols(r_y, BOARD_COLS);
    assign w_base       = prime ? w_prime_base : r_row_base;
    assign addr         = w_base + {9'b0, r_x};

    assign w_x_next   = {1'b0, r_x} + 8'd1;
    assign w_y_next   = {1'b0, r_y} + 7'd1;
    assign w_row_wrap = (w_x_next >= r_x_end);
    assign last       = w_row_wrap && (w_y_next >= r_y_end);

    // Rectangle latch and row-major position update
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x0       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_x_end    <= '0;
            r_y_end    <= '0;
            r_row_base <= '0;
        end else if (load) begin
            r_x0    <= rect_x;
            r_x     <= rect_x;
            r_y     <= rect_y;
            r_x_end <= w_x_end;
            r_y_end <= w_y_end;
        end else if (prime) begin
            r_row_base <= w_prime_base;
        end else if (step) begin
            if (w_row_wrap) begin
                r_x        <= r_x0;
                r_y        <= w_y_next[5:0];
                r_row_base <= r_row_base + c_COLS16;
            end else begin
                r_x <= w_x_next[6:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gfx_cmd_writer.sv
`default_nettype none
// ============================================================================
// Module      : gfx_cmd_writer
// Description : Turns single-write and board-fill commands into timed
//               operation/data bursts for the pixel compute block. Each
//               burst of n words is framed as PRIME, n x WRITE, TAIL so the
//               consumer's registered write enable catches every word.
// Revision    : 1.0 - initial release
// ============================================================================
module gfx_cmd_writer #(
    parameter int BOARD_COLS = gfx_pkg::BOARD_COLS,
    parameter int BOARD_ROWS = gfx_pkg::BOARD_ROWS
) (
    input  wire logic        clock,
    input  wire logic        reset,
    gfx_cmd_writer_if.slave  bus
);
    import gfx_pkg::state_t;
    import gfx_pkg::c_ST_IDLE;
    import gfx_pkg::c_ST_PRIME;
    import gfx_pkg::c_ST_WRITE;
    import gfx_pkg::c_ST_TAIL;
    import gfx_pkg::c_ST_DONE;
    import gfx_pkg::TGT_NONE;
    import gfx_pkg::TGT_BOARD;
    import gfx_pkg::make_op;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_fill;
    logic [1:0]  r_target;
    logic [15:0] r_addr;
    logic [31:0] r_data;

    logic        w_accept;
    logic        w_empty;
    logic        w_prime;
    logic        w_step;
    logic        w_walk_last;
    logic        w_last;
    logic        w_active;
    logic [15:0] w_walk_addr;
    logic [1:0]  w_word_tgt;
    logic [15:0] w_word_addr;

    assign bus.cmd_ready = (r_state == c_ST_IDLE) && !reset;
    assign w_accept      = bus.cmd_valid && bus.cmd_ready;
    assign w_prime       = (r_state == c_ST_PRIME);

    rect_walker #(
        .BOARD_COLS (BOARD_COLS),
        .BOARD_ROWS (BOARD_ROWS)
    ) u_walker (
        .clock  (clock),
        .reset  (reset),
        .load   (w_accept),
        .prime  (w_prime),
        .step   (w_step),
        .rect_x (bus.rect_x),
        .rect_y (bus.rect_y),
        .rect_w (bus.rect_w),
        .rect_h (bus.rect_h),
        .empty  (w_empty),
        .addr   (w_walk_addr),
        .last   (w_walk_last)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command latch; inputs are ignored for the rest of the command
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fill   <= 1'b0;
            r_target <= TGT_NONE;
            r_addr   <= '0;
            r_data   <= '0;
        end else if (w_accept) begin
            r_fill   <= bus.cmd_fill;
            r_target <= bus.cmd_target;
            r_addr   <= bus.cmd_addr;
            r_data   <= bus.cmd_data;
        end
    end

    // A single write is a one-word burst
    assign w_last = r_fill ? w_walk_last : 1'b1;

    // Next-state and walker stepping
    always_comb begin
        w_state_next = r_state;
        w_step       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (bus.cmd_fill) begin
                        w_state_next = w_empty ? c_ST_DONE : c_ST_PRIME;
                    end else begin
                        w_state_next = (bus.cmd_target == TGT_NONE) ? c_ST_DONE : c_ST_PRIME;
                    end
                end
            end
            c_ST_PRIME: w_state_next = c_ST_WRITE;
            c_ST_WRITE: begin
                if (w_last) begin
                    w_state_next = c_ST_TAIL;
                end else begin
                    w_step = 1'b1;
                end
            end
            c_ST_TAIL:  w_state_next = c_ST_DONE;
            c_ST_DONE:  w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // Output words; forced to zero while reset is held
    assign w_active    = !reset && ((r_state == c_ST_PRIME) ||
                                    (r_state == c_ST_WRITE) ||
                                    (r_state == c_ST_TAIL));
    assign w_word_tgt  = r_fill ? TGT_BOARD : r_target;
    assign w_word_addr = r_fill ? w_walk_addr : r_addr;

    assign bus.operation = w_active ? make_op(w_word_tgt, w_word_addr) : '0;
    assign bus.data      = w_active ? r_data : '0;
    assign bus.busy      = !reset && (r_state != c_ST_IDLE);
    assign bus.done      = !reset && (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_gfx_cmd_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gfx_cmd_writer
// Description : Self-checking bench for gfx_cmd_writer. A reference model
//               expands each command into its list of written addresses and
//               a consumer model (registered enable, write on the following
//               edge) collects the writes that actually land.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gfx_cmd_writer;

    localparam int COLS = 80;
    localparam int ROWS = 34;

    typedef struct {
        logic        fill;
        logic [1:0]  tgt;
        logic [15:0] addr;
        logic [31:0] data;
        logic [6:0]  x;
        logic [5:0]  y;
        logic [6:0]  w;
        logic [5:0]  h;
    } cmd_t;

    typedef struct {
        cmd_t        c;
        int          exp_n;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    logic clock;
    logic reset;

    gfx_cmd_writer_if bus ();

    gfx_cmd_writer #(
        .BOARD_COLS (COLS),
        .BOARD_ROWS (ROWS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cons_mem [int];
    logic [31:0] exp_mem  [int];
    logic [1:0]  cons_wren;
    logic [31:0] mdl_q [$];
    vec_t        tbl [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Consumer: enable registered from the target field on one edge; the
    // word present on the next edge is stored if it still names that target.
    always @(posedge clock) begin
        if (reset) begin
            cons_wren = 2'b00;
        end else begin
            if (cons_wren != 2'b00 && bus.operation[17:16] == cons_wren)
                cons_mem[int'({cons_wren, bus.operation[15:0]})] = bus.data;
            cons_wren = bus.operation[17:16];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic fill, input logic [1:0] tgt, input logic [15:0] addr,
                                input logic [31:0] data, input int x, input int y, input int w, input int h);
        cmd_t c;
        c.fill = fill; c.tgt = tgt; c.addr = addr; c.data = data;
        c.x = 7'(x); c.y = 6'(y); c.w = 7'(w); c.h = 6'(h);
        return c;
    endfunction

    // Reference: list of operation words a command must write, row-major with clipping
    function automatic void model_build(input cmd_t c);
        int xe;
        int ye;
        mdl_q.delete();
        if (!c.fill) begin
            if (c.tgt != 2'b00) mdl_q.push_back({14'b0, c.tgt, c.addr});
        end else begin
            xe = int'(c.x) + int'(c.w);
            ye = int'(c.y) + int'(c.h);
            if (xe > COLS) xe = COLS;
            if (ye > ROWS) ye = ROWS;
            for (int yy = int'(c.y); yy < ye; yy++)
                for (int xx = int'(c.x); xx < xe; xx++)
                    mdl_q.push_back(32'h0001_0000 | 32'(yy * COLS + xx));
        end
    endfunction

    task automatic drive(input cmd_t c);
        bus.cmd_fill   = c.fill;
        bus.cmd_target = c.tgt;
        bus.cmd_addr   = c.addr;
        bus.cmd_data   = c.data;
        bus.rect_x     = c.x;
        bus.rect_y     = c.y;
        bus.rect_w     = c.w;
        bus.rect_h     = c.h;
    endtask

    // Returns after the accepting edge (sampled #1 later); waited = idle cycles spent
    task automatic wait_accept(input string name, output int waited);
        waited = 0;
        while (waited < 50) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                @(posedge clock); #1;
                return;
            end
            @(posedge clock); #1;
            waited++;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s accept: cmd_ready=%0b after 50 cycles, expected 1", name, bus.cmd_ready);
    endtask

    // Observe one command from the cycle after acceptance until done, then one idle cycle
    task automatic collect(input cmd_t c, input string name,
                           output int obs_n, output logic [31:0] first_op, output logic [31:0] last_op);
        logic [31:0] exp_ops [$];
        logic [31:0] obs_ops [$];
        logic [31:0] obs_dat [$];
        int n, exp_done, cyc, nz, bad_op, bad_dat;
        bit got, busy_ok;
        model_build(c);
        n = mdl_q.size();
        if (n > 0) begin
            exp_ops.push_back(mdl_q[0]);
            foreach (mdl_q[i]) exp_ops.push_back(mdl_q[i]);
            exp_ops.push_back(mdl_q[n-1]);
        end
        exp_ops.push_back(32'h0);
        exp_done = (n == 0) ? 1 : n + 3;
        cyc = 1; got = 0; busy_ok = 1;
        while (cyc <= exp_done + 20) begin
            obs_ops.push_back(bus.operation);
            obs_dat.push_back(bus.data);
            if (!bus.busy || bus.cmd_ready) busy_ok = 0;
            if (bus.done) begin
                got = 1;
                break;
            end
            @(posedge clock); #1;
            cyc++;
        end
        check({name, " done seen"}, 64'(got), 64'd1);
        check({name, " done latency"}, 64'(cyc), 64'(exp_done));
        check({name, " busy high/ready low"}, 64'(busy_ok), 64'd1);
        bad_op = -1; bad_dat = 0;
        for (int i = 0; i < exp_ops.size() && i < obs_ops.size(); i++) begin
            if (bad_op < 0 && obs_ops[i] !== exp_ops[i]) bad_op = i;
            if (exp_ops[i] != 32'h0 && obs_dat[i] !== c.data) bad_dat++;
        end
        if (bad_op >= 0)
            check($sformatf("%s op word %0d", name, bad_op), 64'(obs_ops[bad_op]), 64'(exp_ops[bad_op]));
        else
            check({name, " op stream length"}, 64'(obs_ops.size()), 64'(exp_ops.size()));
        check({name, " data words wrong"}, 64'(bad_dat), 64'd0);
        nz = 0; last_op = 32'h0;
        foreach (obs_ops[i]) if (obs_ops[i] != 32'h0) begin nz++; last_op = obs_ops[i]; end
        obs_n    = (nz > 2) ? nz - 2 : ((nz > 0) ? 1 : 0);
        first_op = obs_ops[0];
        foreach (mdl_q[i]) exp_mem[int'(mdl_q[i][17:0])] = c.data;
        @(posedge clock); #1;
        check({name, " idle after done {done,busy,ready,op==0}"},
              64'({bus.done, bus.busy, bus.cmd_ready, bus.operation == 32'h0}), 64'b0011);
    endtask

    task automatic run_cmd(input cmd_t c, input string name,
                           output int obs_n, output logic [31:0] first_op, output logic [31:0] last_op);
        int waited;
        drive(c);
        bus.cmd_valid = 1'b1;
        wait_accept(name, waited);
        bus.cmd_valid = 1'b0;
        collect(c, name, obs_n, first_op, last_op);
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = 0;
        if (cons_mem.size() != exp_mem.size()) bad++;
        foreach (exp_mem[k])
            if (!cons_mem.exists(k) || cons_mem[k] !== exp_mem[k]) bad++;
        check({name, " consumer memory differences"}, 64'(bad), 64'd0);
    endtask

    task automatic add_vec(input cmd_t c, input int n, input logic [31:0] f, input logic [31:0] l);
        vec_t v;
        v.c = c; v.exp_n = n; v.exp_first = f; v.exp_last = l;
        tbl.push_back(v);
    endtask

    initial begin
        int          obs_n, waited;
        logic [31:0] f_op, l_op;
        cmd_t        ca, cb;
        string       nm;

        add_vec(mk(0, 2'b11, 16'd5,      32'h00FF8800, 0, 0, 0, 0), 1,  32'h0003_0005, 32'h0003_0005);
        add_vec(mk(1, 2'b00, 16'd0,      32'd7,        3, 1, 2, 2), 4,  32'h0001_0053, 32'h0001_00A4);
        add_vec(mk(1, 2'b00, 16'd0,      32'h000000A5, 78, 33, 5, 4), 2, 32'h0001_0A9E, 32'h0001_0A9F);
        add_vec(mk(1, 2'b00, 16'd0,      32'd3,        10, 10, 0, 3), 0, 32'h0, 32'h0);
        add_vec(mk(1, 2'b00, 16'd0,      32'd3,        80, 2, 4, 2),  0, 32'h0, 32'h0);
        add_vec(mk(1, 2'b00, 16'd0,      32'd3,        5, 34, 3, 3),  0, 32'h0, 32'h0);
        add_vec(mk(0, 2'b00, 16'd9,      32'd1,        0, 0, 0, 0),   0, 32'h0, 32'h0);
        add_vec(mk(1, 2'b11, 16'h1234,   32'h8000_001F, 79, 0, 1, 1), 1, 32'h0001_004F, 32'h0001_004F);
        add_vec(mk(1, 2'b00, 16'd0,      32'd12,       0, 33, 80, 1), 80, 32'h0001_0A50, 32'h0001_0A9F);
        add_vec(mk(0, 2'b10, 16'hFFFF,   32'hDEADBEEF, 0, 0, 0, 0),  1, 32'h0002_FFFF, 32'h0002_FFFF);

        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        drive(mk(0, 2'b00, 16'd0, 32'd0, 0, 0, 0, 0));
        repeat (3) @(posedge clock);
        #1;
        check("reset {ready,busy,done}", 64'({bus.cmd_ready, bus.busy, bus.done}), 64'b000);
        check("reset operation", 64'(bus.operation), 64'd0);
        check("reset data", 64'(bus.data), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("ready after reset", 64'(bus.cmd_ready), 64'd1);

        foreach (tbl[i]) begin
            nm = $sformatf("vec%0d", i);
            run_cmd(tbl[i].c, nm, obs_n, f_op, l_op);
            check({nm, " write count"}, 64'(obs_n), 64'(tbl[i].exp_n));
            check({nm, " first op"}, 64'(f_op), 64'(tbl[i].exp_first));
            check({nm, " last op"}, 64'(l_op), 64'(tbl[i].exp_last));
            check_mem(nm);
        end

        // Back-to-back with cmd_valid held: second command's fields appear
        // right after the first is accepted and must not disturb it.
        ca = mk(1, 2'b00, 16'd0, 32'h11, 10, 2, 3, 1);
        cb = mk(0, 2'b10, 16'h0123, 32'h22, 0, 0, 0, 0);
        drive(ca);
        bus.cmd_valid = 1'b1;
        wait_accept("b2b first", waited);
        drive(cb);
        collect(ca, "b2b first", obs_n, f_op, l_op);
        wait_accept("b2b second", waited);
        check("b2b second accepted on first idle cycle", 64'(waited), 64'd0);
        bus.cmd_valid = 1'b0;
        collect(cb, "b2b second", obs_n, f_op, l_op);
        check_mem("b2b");

        // Reset in the middle of a 10x1 fill at row 5 (addresses 400..409)
        drive(mk(1, 2'b00, 16'd0, 32'h5A, 0, 5, 10, 1));
        bus.cmd_valid = 1'b1;
        wait_accept("mid reset", waited);
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("mid reset op before reset", 64'(bus.operation), 64'(32'h0001_0000 | 32'd402));
        reset = 1'b1;
        @(posedge clock); #1;
        check("mid reset op during reset", 64'(bus.operation), 64'd0);
        check("mid reset {busy,done}", 64'({bus.busy, bus.done}), 64'b00);
        reset = 1'b0;
        @(posedge clock); #1;
        check("mid reset idle {done,busy,ready,op==0}",
              64'({bus.done, bus.busy, bus.cmd_ready, bus.operation == 32'h0}), 64'b0011);
        exp_mem[int'(18'h1_0000 | 18'd400)] = 32'h5A;
        exp_mem[int'(18'h1_0000 | 18'd401)] = 32'h5A;
        repeat (3) @(posedge clock);
        #1;
        check("mid reset op stays 0", 64'(bus.operation), 64'd0);
        check_mem("mid reset");

        // Randomized commands against the reference model
        for (int i = 0; i < 40; i++) begin
            ca = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), $urandom,
                    int'($urandom_range(0, 85)), int'($urandom_range(0, 37)),
                    int'($urandom_range(0, 9)), int'($urandom_range(0, 5)));
            run_cmd(ca, $sformatf("rand%0d", i), obs_n, f_op, l_op);
        end
        check_mem("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
